// File: rtl/clock_ctrl.sv
// Time-of-day clock with RUN/SET_HR/SET_MIN/SET_SEC set-mode FSM.
// Define CLOCK_CTRL_12H_EN for 12-hour display with PM indicator (default is 24-hour).
//
// state | meaning
// 00    | RUN     - time advances on tick_in, inc_in ignored
// 01    | SET_HR  - inc_in steps hours, clock frozen
// 10    | SET_MIN - inc_in steps minutes, clock frozen
// 11    | SET_SEC - inc_in clears seconds, clock frozen
module clock_ctrl #(
  parameter int FIELD_W = 8
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               tick_in,
  input  logic               mode_in,
  input  logic               inc_in,
  output logic [FIELD_W-1:0] sec_out,
  output logic [FIELD_W-1:0] min_out,
  output logic [FIELD_W-1:0] hr_out,
  output logic [1:0]         state_out,
  output logic               pm_out,
  output logic               carry_out
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_HR  = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;
  localparam logic [1:0] ST_SET_SEC = 2'b11;

  localparam logic [FIELD_W-1:0] MS_MAX = FIELD_W'(59);

`ifdef CLOCK_CTRL_12H_EN
  localparam logic [FIELD_W-1:0] HR_MIN = FIELD_W'(1);
  localparam logic [FIELD_W-1:0] HR_MAX = FIELD_W'(12);
  localparam logic [FIELD_W-1:0] HR_RST = FIELD_W'(12);
`else
  localparam logic [FIELD_W-1:0] HR_MIN = FIELD_W'(0);
  localparam logic [FIELD_W-1:0] HR_MAX = FIELD_W'(23);
  localparam logic [FIELD_W-1:0] HR_RST = FIELD_W'(0);
`endif

  logic [FIELD_W-1:0] hr_inc;
  logic               pm_toggle;
  logic               day_wrap;
  logic               set_inc;

  always_comb begin
    hr_inc  = (hr_out == HR_MAX) ? HR_MIN : hr_out + FIELD_W'(1);
    set_inc = inc_in && !mode_in;
`ifdef CLOCK_CTRL_12H_EN
    // PM flips on the 11 -> 12 step; the day ends at 11 PM -> 12 AM.
    pm_toggle = (hr_out == FIELD_W'(11));
    day_wrap  = pm_toggle && pm_out;
`else
    pm_toggle = 1'b0;
    day_wrap  = (hr_out == HR_MAX);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_out <= ST_RUN;
      sec_out   <= '0;
      min_out   <= '0;
      hr_out    <= HR_RST;
      pm_out    <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      case (state_out)
        ST_RUN: begin
          if (tick_in) begin
            if (sec_out == MS_MAX) begin
              sec_out <= '0;
              if (min_out == MS_MAX) begin
                min_out   <= '0;
                hr_out    <= hr_inc;
                pm_out    <= pm_out ^ pm_toggle;
                carry_out <= day_wrap;
              end else begin
                min_out <= min_out + FIELD_W'(1);
              end
            end else begin
              sec_out <= sec_out + FIELD_W'(1);
            end
          end
        end
        ST_SET_HR: begin
          if (set_inc) begin
            hr_out <= hr_inc;
            pm_out <= pm_out ^ pm_toggle;
          end
        end
        ST_SET_MIN: begin
          if (set_inc) min_out <= (min_out == MS_MAX) ? '0 : min_out + FIELD_W'(1);
        end
        default: begin
          if (set_inc) sec_out <= '0;
        end
      endcase
      if (mode_in) state_out <= state_out + 2'd1;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Testbench for clock_ctrl: seconds-of-day reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours CLOCK_CTRL_12H_EN.
module tb_clock_ctrl;
  localparam int FW = 8;

  logic          clk_in = 1'b0;
  logic          reset_in, tick_in, mode_in, inc_in;
  logic [FW-1:0] sec_out, min_out, hr_out;
  logic [1:0]    state_out;
  logic          pm_out, carry_out;

  int checks = 0;
  int passes = 0;

  clock_ctrl #(.FIELD_W(FW)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .tick_in(tick_in), .mode_in(mode_in),
    .inc_in(inc_in), .sec_out(sec_out), .min_out(min_out), .hr_out(hr_out),
    .state_out(state_out), .pm_out(pm_out), .carry_out(carry_out)
  );

  always #5 clk_in = ~clk_in;

`ifdef CLOCK_CTRL_12H_EN
  localparam int RST_HR = 12;
`else
  localparam int RST_HR = 0;
`endif

  // Reference model: time held as seconds since midnight.
  int  m_t = 0;
  int  m_st = 0;
  bit  m_carry = 0;
  bit  m_valid = 0;
  int  mh, mm, ms;

  always @(posedge clk_in) begin
    if (reset_in) begin
      m_t = 0; m_st = 0; m_carry = 0; m_valid = 1;
    end else if (m_valid) begin
      m_carry = 0;
      mh = m_t / 3600; mm = (m_t / 60) % 60; ms = m_t % 60;
      if (m_st == 0) begin
        if (tick_in) begin
          m_t = (m_t + 1) % 86400;
          m_carry = (m_t == 0);
        end
      end else if (inc_in && !mode_in) begin
        if (m_st == 1) mh = (mh + 1) % 24;
        else if (m_st == 2) mm = (mm + 1) % 60;
        else ms = 0;
        m_t = mh * 3600 + mm * 60 + ms;
      end
      if (mode_in) m_st = (m_st + 1) % 4;
    end
  end

  function automatic int exp_hr(int t);
    int h24 = t / 3600;
`ifdef CLOCK_CTRL_12H_EN
    return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    return h24;
`endif
  endfunction

  function automatic int exp_pm(int t);
`ifdef CLOCK_CTRL_12H_EN
    return (t / 3600 >= 12) ? 1 : 0;
`else
    return (t < 0) ? 1 : 0;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("model_state", int'(state_out), m_st);
      check("model_sec",   int'(sec_out),   m_t % 60);
      check("model_min",   int'(min_out),   (m_t / 60) % 60);
      check("model_hr",    int'(hr_out),    exp_hr(m_t));
      check("model_pm",    int'(pm_out),    exp_pm(m_t));
      check("model_carry", int'(carry_out), int'(m_carry));
    end
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(bit r, bit t, bit m, bit i);
    reset_in = r; tick_in = t; mode_in = m; inc_in = i;
    @(posedge clk_in);
    #1;
    reset_in = 0; tick_in = 0; mode_in = 0; inc_in = 0;
  endtask

  task automatic rep(int n, bit t, bit m, bit i);
    for (int k = 0; k < n; k++) cyc(0, t, m, i);
  endtask

  int carry_seen;

  initial begin
    reset_in = 1; tick_in = 0; mode_in = 0; inc_in = 0;
    @(negedge clk_in);
    cyc(1, 0, 0, 0);
    check("rst_state", state_out, 0);
    check("rst_sec", sec_out, 0);
    check("rst_min", min_out, 0);
    check("rst_hr", hr_out, RST_HR);
    check("rst_pm", pm_out, 0);
    check("rst_carry", carry_out, 0);

    // 60 ticks -> 00:01:00
    carry_seen = 0;
    for (int k = 0; k < 60; k++) begin
      cyc(0, 1, 0, 0);
      if (carry_out) carry_seen++;
    end
    check("t60_sec", sec_out, 0);
    check("t60_min", min_out, 1);
    check("t60_hr", hr_out, RST_HR);
    check("t60_carry_seen", carry_seen, 0);

    // inc ignored in RUN; mode+tick in RUN applies tick and enters SET_HR
    rep(3, 0, 0, 1);
    check("run_inc_ignored_min", min_out, 1);
    cyc(0, 1, 1, 0);
    check("mode_tick_run_state", state_out, 1);
    check("mode_tick_run_sec", sec_out, 1);
    rep(2, 0, 1, 0);
    cyc(0, 1, 1, 0);
    check("mode_tick_setsec_state", state_out, 0);
    check("mode_tick_setsec_sec", sec_out, 1);

    // Preload 23:59:58 and roll over
    cyc(1, 0, 0, 0);
    rep(58, 1, 0, 0);
    cyc(0, 0, 1, 0);
    rep(23, 0, 0, 1);
    cyc(0, 0, 1, 0);
    rep(59, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("pre_state", state_out, 0);
    check("pre_sec", sec_out, 58);
    check("pre_min", min_out, 59);
`ifdef CLOCK_CTRL_12H_EN
    check("pre_hr", hr_out, 11);
    check("pre_pm", pm_out, 1);
`else
    check("pre_hr", hr_out, 23);
`endif
    cyc(0, 1, 0, 0);
    check("t1_sec", sec_out, 59);
    check("t1_carry", carry_out, 0);
    cyc(0, 1, 0, 0);
    check("wrap_sec", sec_out, 0);
    check("wrap_min", min_out, 0);
    check("wrap_hr", hr_out, RST_HR);
    check("wrap_pm", pm_out, 0);
    check("wrap_carry", carry_out, 1);
    cyc(0, 0, 0, 0);
    check("wrap_carry_drop", carry_out, 0);

    // Set hours / minutes; ticks frozen in set mode
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    rep(5, 0, 0, 1);
    check("set_hr_state", state_out, 1);
    check("set_hr5", hr_out, 5);
    cyc(0, 0, 1, 0);
    check("set_min_state", state_out, 2);
    rep(61, 0, 0, 1);
    check("set_min61", min_out, 1);
    check("set_min_hr_nocarry", hr_out, 5);
    rep(4, 1, 0, 0);
    check("set_tick_frozen", sec_out, 0);

    // Same-cycle mode+inc in SET_HR, then reset mid-set
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    rep(3, 0, 0, 1);
    cyc(0, 0, 1, 1);
    check("modeinc_state", state_out, 2);
    check("modeinc_hr", hr_out, 3);
    rep(2, 0, 0, 1);
    cyc(1, 1, 1, 1);
    check("midset_rst_state", state_out, 0);
    check("midset_rst_min", min_out, 0);
    check("midset_rst_hr", hr_out, RST_HR);
    check("midset_rst_sec", sec_out, 0);

    // Clear seconds in SET_SEC
    rep(7, 1, 0, 0);
    rep(3, 0, 1, 0);
    cyc(0, 0, 0, 1);
    check("set_sec_clear", sec_out, 0);
    cyc(0, 0, 1, 0);

`ifdef CLOCK_CTRL_12H_EN
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    rep(11, 0, 0, 1);
    check("h12_hr11", hr_out, 11);
    check("h12_pm11", pm_out, 0);
    cyc(0, 0, 0, 1);
    check("h12_hr12", hr_out, 12);
    check("h12_pm12", pm_out, 1);
    cyc(0, 0, 0, 1);
    check("h12_hr1", hr_out, 1);
    check("h12_pm1", pm_out, 1);
`endif

    @(negedge clk_in);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
